// File: rtl/tone_nco_pkg.sv
// tone_nco_pkg: shared widths, sample type and gain helper for the tone NCO.
// apply_gain is only referenced when TONE_NCO_GAIN_EN is defined.
package tone_nco_pkg;

    localparam int LUT_W  = 16;
    localparam int ADDR_W = 10;
    localparam int GAIN_W = 8;
    localparam int QTR_W  = ADDR_W - 2;
    localparam int MAG_W  = LUT_W - 1;
    localparam int PROD_W = LUT_W + GAIN_W + 1;

    typedef logic signed [LUT_W-1:0] sample_t;

    // Unsigned gain in 1/256 steps; floor division keeps it arithmetic.
    function automatic sample_t apply_gain(
        input sample_t           s,
        input logic [GAIN_W-1:0] g
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
        return sample_t'(p >>> GAIN_W);
    endfunction

endpackage

// File: rtl/nco_cos_lut.sv
// nco_cos_lut: quarter-wave cosine ROM, quadrant mirroring and sign.
// One registered output stage, loaded when i_ld is high.
module nco_cos_lut
    import tone_nco_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld,
    input  logic [ADDR_W-1:0] i_addr,
    output sample_t           o_dat
);

    localparam int  QTR_N = 1 << QTR_W;
    localparam real PI    = 3.14159265358979323846;

    logic [MAG_W-1:0] w_rom [QTR_N];

    for (genvar g = 0; g < QTR_N; g++) begin : g_rom
        localparam real ANG = 2.0 * PI * real'(g) / real'(QTR_N * 4);
        localparam int  VAL = $rtoi(32767.0 * $cos(ANG) + 0.5);
        assign w_rom[g] = MAG_W'(VAL);
    end

    logic [1:0]       w_quad;
    logic [QTR_W-1:0] w_idx;
    logic [QTR_W-1:0] w_sel;
    logic             w_zero;
    logic             w_neg;
    logic [MAG_W-1:0] w_mag;
    sample_t          w_val;
    sample_t          r_dat;

    assign w_quad = i_addr[ADDR_W-1 -: 2];
    assign w_idx  = i_addr[QTR_W-1:0];

    // Odd quadrants read the table backwards; their index 0 is a zero crossing.
    assign w_sel  = w_quad[0] ? (~w_idx + QTR_W'(1)) : w_idx;
    assign w_zero = w_quad[0] && (w_idx == '0);
    assign w_neg  = w_quad[0] ^ w_quad[1];
    assign w_mag  = w_zero ? '0 : w_rom[w_sel];
    assign w_val  = w_neg ? -sample_t'({1'b0, w_mag})
                          :  sample_t'({1'b0, w_mag});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dat <= '0;
        end else if (i_ld) begin
            r_dat <= w_val;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/tone_nco.sv
// tone_nco: multi-channel cosine NCO with valid/ack output and overrun flag.
// Define TONE_NCO_GAIN_EN to add i_gain and a registered gain stage.
module tone_nco
    import tone_nco_pkg::*;
#(
    parameter int p_channels = 2,
    parameter int p_phase_w  = 24,
    parameter int p_divider  = 1000
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [p_channels-1:0]                i_en,
    input  logic [p_channels-1:0][p_phase_w-1:0] i_ftw,
    input  logic                                 i_clr,
`ifdef TONE_NCO_GAIN_EN
    input  logic [p_channels-1:0][GAIN_W-1:0]    i_gain,
`endif
    output logic [p_channels-1:0][LUT_W-1:0]     o_dat,
    output logic                                 o_vld,
    input  logic                                 i_ack,
    output logic                                 o_ovf
);

    localparam int               CNT_W   = $clog2(p_divider);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(p_divider - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic                 r_tick;
    logic                 r_ld1;
    logic [p_phase_w-1:0] r_phase [p_channels];
    sample_t              w_lut   [p_channels];
    logic                 w_load;
    logic                 r_vld;
    logic                 r_ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_ld1  <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
            r_tick <= (r_cnt == CNT_MAX);
            r_ld1  <= r_tick;
        end
    end

    for (genvar c = 0; c < p_channels; c++) begin : g_ch
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_phase[c] <= '0;
            end else if (i_clr) begin
                r_phase[c] <= '0;
            end else if (r_tick && i_en[c]) begin
                r_phase[c] <= r_phase[c] + i_ftw[c];
            end
        end

        nco_cos_lut u_lut (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_ld   (r_ld1),
            .i_addr (r_phase[c][p_phase_w-1 -: ADDR_W]),
            .o_dat  (w_lut[c])
        );
    end

`ifdef TONE_NCO_GAIN_EN
    logic    r_ld2;
    sample_t r_dat [p_channels];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ld2 <= 1'b0;
        end else begin
            r_ld2 <= r_ld1;
        end
    end

    for (genvar c = 0; c < p_channels; c++) begin : g_gain
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_dat[c] <= '0;
            end else if (r_ld2) begin
                r_dat[c] <= apply_gain(w_lut[c], i_gain[c]);
            end
        end
        assign o_dat[c] = r_dat[c];
    end

    assign w_load = r_ld2;
`else
    for (genvar c = 0; c < p_channels; c++) begin : g_out
        assign o_dat[c] = w_lut[c];
    end

    assign w_load = r_ld1;
`endif

    // A load always wins over ack; unacked loads mark the overrun.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_vld <= 1'b1;
            if (r_vld && !i_ack) begin
                r_ovf <= 1'b1;
            end
        end else if (i_ack) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_ovf = r_ovf;

endmodule
